// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store control stage.
//   state_t      : control FSM states (IDLE, ACCESS, RESP)
//   MT_*         : data-memory mem_type encodings
//   F3_*         : RISC-V funct3 codes for loads and stores
//   decode_f3()  : funct3 -> {legal, mem_type, access size in bytes}
// ---------------------------------------------------------------------------
package lsu_pkg;

   localparam int DEFAULT_DEPTH_BYTES = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Data-memory access type encodings.
   localparam logic [2:0] MT_BYTE   = 3'b000;
   localparam logic [2:0] MT_HALF   = 3'b001;
   localparam logic [2:0] MT_WORD   = 3'b010;
   localparam logic [2:0] MT_BYTE_U = 3'b011;
   localparam logic [2:0] MT_HALF_U = 3'b100;

   // RISC-V funct3 for loads.
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // RISC-V funct3 for stores.
   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   typedef struct packed {
      logic       legal;
      logic [2:0] mtype;
      logic [2:0] size;
   } decode_t;

   // Illegal codes decode to MT_BYTE / size 1 so downstream fields stay defined.
   function automatic decode_t decode_f3(input logic we, input logic [2:0] f3);
      decode_t d;
      d = '{legal: 1'b0, mtype: MT_BYTE, size: 3'd1};
      if (we) begin
         case (f3)
            F3_SB:   d = '{legal: 1'b1, mtype: MT_BYTE, size: 3'd1};
            F3_SH:   d = '{legal: 1'b1, mtype: MT_HALF, size: 3'd2};
            F3_SW:   d = '{legal: 1'b1, mtype: MT_WORD, size: 3'd4};
            default: d = '{legal: 1'b0, mtype: MT_BYTE, size: 3'd1};
         endcase
      end else begin
         case (f3)
            F3_LB:   d = '{legal: 1'b1, mtype: MT_BYTE,   size: 3'd1};
            F3_LH:   d = '{legal: 1'b1, mtype: MT_HALF,   size: 3'd2};
            F3_LW:   d = '{legal: 1'b1, mtype: MT_WORD,   size: 3'd4};
            F3_LBU:  d = '{legal: 1'b1, mtype: MT_BYTE_U, size: 3'd1};
            F3_LHU:  d = '{legal: 1'b1, mtype: MT_HALF_U, size: 3'd2};
            default: d = '{legal: 1'b0, mtype: MT_BYTE,   size: 3'd1};
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
// Request/response handshake between the execute/memory stage and lsu_ctrl.
//   req_*   : one memory request per req_valid && req_ready
//   flush   : kill the in-flight request
//   resp_*  : one-cycle response towards writeback
//   busy    : stall indication (high while the memory access is in flight)
// master = pipeline side, slave = lsu_ctrl.
// ---------------------------------------------------------------------------
interface lsu_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        flush;
   logic        resp_valid;
   logic        resp_wb;
   logic [4:0]  resp_rd;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        busy;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, flush,
      input  req_ready, resp_valid, resp_wb, resp_rd, resp_data, resp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, flush,
      output req_ready, resp_valid, resp_wb, resp_rd, resp_data, resp_err, busy
   );

endinterface

// File: rtl/lsu_load_ext.sv
// ---------------------------------------------------------------------------
// lsu_load_ext
// Combinational load-data extender.
//   mem_type : access type (MT_* from lsu_pkg)
//   rdata    : raw 32-bit data returned by the memory, right-aligned
//   result   : sign/zero-extended load value
// ---------------------------------------------------------------------------
module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic [2:0]  mem_type,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      result = rdata;
      case (mem_type)
         MT_BYTE:   result = {{24{rdata[7]}}, rdata[7:0]};
         MT_HALF:   result = {{16{rdata[15]}}, rdata[15:0]};
         MT_BYTE_U: result = {24'h0, rdata[7:0]};
         MT_HALF_U: result = {16'h0, rdata[15:0]};
         default:   result = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
// Load/store control stage in front of the byte-addressed data memory.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : lsu_if.slave request/response handshake, flush, busy
//   mem_rd_en    : memory read enable (one cycle, legal loads)
//   mem_wr_en    : memory write enable (one cycle, legal unflushed stores)
//   mem_type     : memory access type
//   mem_addr     : byte address
//   mem_wdata    : store data, right-aligned
//   mem_rdata    : asynchronous read data from memory
// A request spends one cycle in ACCESS (memory enables driven) and one in
// RESP (response pulse); a new request can be accepted during RESP.
// ---------------------------------------------------------------------------
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int DEPTH_BYTES = DEFAULT_DEPTH_BYTES
) (
   input  logic        clk,
   input  logic        rst_n,
   lsu_if.slave        bus,
   output logic        mem_rd_en,
   output logic        mem_wr_en,
   output logic [2:0]  mem_type,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   state_t      state_q;
   logic        we_q;
   logic        err_q;
   logic [2:0]  type_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [4:0]  rd_q;
   logic        resp_wb_q;
   logic        resp_err_q;
   logic [31:0] resp_data_q;

   decode_t     req_dec;
   logic [32:0] req_end;
   logic        req_err;
   logic        accept;
   logic        in_access;
   logic        load_ok;
   logic [31:0] ext_data;

   // Range check in 33 bits so an address near 2^32 cannot wrap to legal.
   assign req_dec = decode_f3(bus.req_we, bus.req_funct3);
   assign req_end = {1'b0, bus.req_addr} + 33'(req_dec.size);
   assign req_err = !req_dec.legal || (req_end > 33'(DEPTH_BYTES));

   // A request offered together with a flush in RESP is dropped.
   assign accept = bus.req_valid && bus.req_ready && !((state_q == RESP) && bus.flush);

   assign in_access = (state_q == ACCESS);
   assign load_ok   = !we_q && !err_q;

   lsu_load_ext u_load_ext (
      .mem_type (type_q),
      .rdata    (mem_rdata),
      .result   (ext_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         type_q      <= MT_BYTE;
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_q        <= '0;
         resp_wb_q   <= 1'b0;
         resp_err_q  <= 1'b0;
         resp_data_q <= '0;
      end else begin
         case (state_q)
            IDLE, RESP: begin
               if (accept) begin
                  we_q    <= bus.req_we;
                  err_q   <= req_err;
                  type_q  <= req_dec.mtype;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  rd_q    <= bus.req_rd;
                  state_q <= ACCESS;
               end else begin
                  state_q <= IDLE;
               end
            end
            ACCESS: begin
               resp_wb_q   <= load_ok;
               resp_err_q  <= err_q;
               resp_data_q <= load_ok ? ext_data : 32'h0;
               state_q     <= bus.flush ? IDLE : RESP;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory side: active only in ACCESS; flush gates the write in the same cycle.
   assign mem_rd_en = in_access && load_ok;
   assign mem_wr_en = in_access && we_q && !err_q && !bus.flush;
   assign mem_type  = in_access ? type_q  : 3'b000;
   assign mem_addr  = in_access ? addr_q  : 32'h0;
   assign mem_wdata = in_access ? wdata_q : 32'h0;

   // Pipeline side: ready/busy decode the state register only.
   assign bus.req_ready  = !in_access;
   assign bus.busy       = in_access;
   assign bus.resp_valid = (state_q == RESP) && !bus.flush;
   assign bus.resp_wb    = bus.resp_valid && resp_wb_q;
   assign bus.resp_err   = bus.resp_valid && resp_err_q;
   assign bus.resp_rd    = bus.resp_valid ? rd_q : 5'd0;
   assign bus.resp_data  = bus.resp_valid ? resp_data_q : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
// Self-checking bench for lsu_ctrl with a 32-byte little-endian memory model.
// Table-driven single requests, then hand-written back-to-back, flush and
// reset sequences.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

   logic        clk;
   logic        rst_n;
   logic        mem_rd_en;
   logic        mem_wr_en;
   logic [2:0]  mem_type;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   lsu_if bus ();

   lsu_ctrl #(.DEPTH_BYTES(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .mem_rd_en (mem_rd_en),
      .mem_wr_en (mem_wr_en),
      .mem_type  (mem_type),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- data memory model ----------------
   logic [7:0] mem_model [32];
   logic [4:0] ma;
   int         wr_pulses;

   assign ma = mem_addr[4:0];
   assign mem_rdata = {mem_model[ma + 5'd3], mem_model[ma + 5'd2],
                       mem_model[ma + 5'd1], mem_model[ma]};

   always @(posedge clk) begin
      if (mem_wr_en) begin
         wr_pulses = wr_pulses + 1;
         mem_model[ma] <= mem_wdata[7:0];
         if (mem_type == 3'b001 || mem_type == 3'b010)
            mem_model[ma + 5'd1] <= mem_wdata[15:8];
         if (mem_type == 3'b010) begin
            mem_model[ma + 5'd2] <= mem_wdata[23:16];
            mem_model[ma + 5'd3] <= mem_wdata[31:24];
         end
      end
   end

   // ---------------- checking ----------------
   int n_checks;
   int n_pass;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      else
         n_pass++;
   endtask

   task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_rd     = rd;
   endtask

   task automatic idle_req();
      bus.req_valid = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic        exp_err;
      logic [31:0] exp_data;
      logic [2:0]  exp_type;
   } vec_t;

   vec_t vecs [19];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_rd_en;
      logic exp_wr_en;
      int   w0;

      n_checks  = 0;
      n_pass    = 0;
      wr_pulses = 0;
      for (int i = 0; i < 32; i++) mem_model[i] = 8'h00;

      vecs[0]  = '{"SW 4",       1'b1, 3'b010, 32'd4,  32'hDEADBEEF, 5'd1,  1'b0, 32'h0,        3'b010};
      vecs[1]  = '{"LB 7",       1'b0, 3'b000, 32'd7,  32'h0,        5'd5,  1'b0, 32'hFFFFFFDE, 3'b000};
      vecs[2]  = '{"LBU 7",      1'b0, 3'b100, 32'd7,  32'h0,        5'd6,  1'b0, 32'h000000DE, 3'b011};
      vecs[3]  = '{"LH 6",       1'b0, 3'b001, 32'd6,  32'h0,        5'd7,  1'b0, 32'hFFFFDEAD, 3'b001};
      vecs[4]  = '{"LHU 6",      1'b0, 3'b101, 32'd6,  32'h0,        5'd8,  1'b0, 32'h0000DEAD, 3'b100};
      vecs[5]  = '{"LW 4",       1'b0, 3'b010, 32'd4,  32'h0,        5'd9,  1'b0, 32'hDEADBEEF, 3'b010};
      vecs[6]  = '{"SW 28",      1'b1, 3'b010, 32'd28, 32'h12345678, 5'd2,  1'b0, 32'h0,        3'b010};
      vecs[7]  = '{"LW 28",      1'b0, 3'b010, 32'd28, 32'h0,        5'd10, 1'b0, 32'h12345678, 3'b010};
      vecs[8]  = '{"LW 29",      1'b0, 3'b010, 32'd29, 32'h0,        5'd11, 1'b1, 32'h0,        3'b000};
      vecs[9]  = '{"LD f3=011",  1'b0, 3'b011, 32'd0,  32'h0,        5'd12, 1'b1, 32'h0,        3'b000};
      vecs[10] = '{"ST f3=100",  1'b1, 3'b100, 32'd0,  32'hFFFFFFFF, 5'd13, 1'b1, 32'h0,        3'b000};
      vecs[11] = '{"SH 2",       1'b1, 3'b001, 32'd2,  32'hFFFF8001, 5'd14, 1'b0, 32'h0,        3'b001};
      vecs[12] = '{"LW 0",       1'b0, 3'b010, 32'd0,  32'h0,        5'd15, 1'b0, 32'h80010000, 3'b010};
      vecs[13] = '{"SB 31",      1'b1, 3'b000, 32'd31, 32'h000000A5, 5'd16, 1'b0, 32'h0,        3'b000};
      vecs[14] = '{"LB 31",      1'b0, 3'b000, 32'd31, 32'h0,        5'd17, 1'b0, 32'hFFFFFFA5, 3'b000};
      vecs[15] = '{"SH 31",      1'b1, 3'b001, 32'd31, 32'h0000BBBB, 5'd18, 1'b1, 32'h0,        3'b000};
      vecs[16] = '{"LW 31",      1'b0, 3'b010, 32'd31, 32'h0,        5'd19, 1'b1, 32'h0,        3'b000};
      vecs[17] = '{"LD f3=110",  1'b0, 3'b110, 32'd0,  32'h0,        5'd20, 1'b1, 32'h0,        3'b000};
      vecs[18] = '{"ST f3=111",  1'b1, 3'b111, 32'd0,  32'hFFFFFFFF, 5'd21, 1'b1, 32'h0,        3'b000};

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      bus.flush = 1'b0;
      drive_req(1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
      idle_req();
      #1;
      check("reset req_ready",  32'(bus.req_ready),  32'd1);
      check("reset busy",       32'(bus.busy),       32'd0);
      check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
      check("reset mem_rd_en",  32'(mem_rd_en),      32'd0);
      check("reset mem_wr_en",  32'(mem_wr_en),      32'd0);
      check("reset resp_data",  bus.resp_data,       32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // ---------------- table-driven single requests ----------------
      for (int i = 0; i < 19; i++) begin
         exp_rd_en = !vecs[i].we && !vecs[i].exp_err;
         exp_wr_en = vecs[i].we && !vecs[i].exp_err;
         @(posedge clk); #1;
         drive_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd);
         @(posedge clk); #1;
         idle_req();
         @(negedge clk);
         check({vecs[i].name, " access busy"},      32'(bus.busy),       32'd1);
         check({vecs[i].name, " access req_ready"}, 32'(bus.req_ready),  32'd0);
         check({vecs[i].name, " access mem_rd_en"}, 32'(mem_rd_en),      32'(exp_rd_en));
         check({vecs[i].name, " access mem_wr_en"}, 32'(mem_wr_en),      32'(exp_wr_en));
         check({vecs[i].name, " access resp_valid"}, 32'(bus.resp_valid), 32'd0);
         if (!vecs[i].exp_err) begin
            check({vecs[i].name, " mem_type"}, 32'(mem_type), 32'(vecs[i].exp_type));
            check({vecs[i].name, " mem_addr"}, mem_addr,      vecs[i].addr);
         end
         @(negedge clk);
         check({vecs[i].name, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
         check({vecs[i].name, " resp_err"},   32'(bus.resp_err),   32'(vecs[i].exp_err));
         check({vecs[i].name, " resp_wb"},    32'(bus.resp_wb),    32'(exp_rd_en));
         check({vecs[i].name, " resp_rd"},    32'(bus.resp_rd),    32'(vecs[i].rd));
         check({vecs[i].name, " resp_data"},  bus.resp_data,       vecs[i].exp_data);
         check({vecs[i].name, " resp mem_wr_en"}, 32'(mem_wr_en), 32'd0);
         check({vecs[i].name, " resp req_ready"}, 32'(bus.req_ready), 32'd1);
      end

      // ---------------- back-to-back: load accepted in RESP of a store ----------------
      @(posedge clk); #1;
      w0 = wr_pulses;
      drive_req(1'b1, 3'b010, 32'd8, 32'h11223344, 5'd1);
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      check("b2b store access mem_wr_en", 32'(mem_wr_en), 32'd1);
      @(posedge clk); #1;
      drive_req(1'b0, 3'b010, 32'd8, 32'h0, 5'd22);
      @(negedge clk);
      check("b2b store resp_valid", 32'(bus.resp_valid), 32'd1);
      check("b2b store resp_wb",    32'(bus.resp_wb),    32'd0);
      check("b2b ready in RESP",    32'(bus.req_ready),  32'd1);
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      check("b2b load access resp_valid", 32'(bus.resp_valid), 32'd0);
      check("b2b load access mem_rd_en",  32'(mem_rd_en),      32'd1);
      @(negedge clk);
      check("b2b load resp_valid", 32'(bus.resp_valid), 32'd1);
      check("b2b load resp_data",  bus.resp_data,       32'h11223344);
      check("b2b load resp_rd",    32'(bus.resp_rd),    32'd22);
      check("b2b write pulses",    32'(wr_pulses - w0), 32'd1);

      // ---------------- flush during ACCESS of SB ----------------
      @(posedge clk); #1;
      w0 = wr_pulses;
      drive_req(1'b1, 3'b000, 32'd12, 32'h00000077, 5'd3);
      @(posedge clk); #1;
      idle_req();
      bus.flush = 1'b1;
      @(negedge clk);
      check("flush access mem_wr_en", 32'(mem_wr_en), 32'd0);
      check("flush access busy",      32'(bus.busy),  32'd1);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      check("flush next busy",       32'(bus.busy),       32'd0);
      check("flush next resp_valid", 32'(bus.resp_valid), 32'd0);
      check("flush next req_ready",  32'(bus.req_ready),  32'd1);
      check("flush memory byte 12",  32'(mem_model[12]),  32'h0);
      check("flush write pulses",    32'(wr_pulses - w0), 32'd0);

      // ---------------- flush in RESP with a concurrent request ----------------
      @(posedge clk); #1;
      drive_req(1'b0, 3'b010, 32'd4, 32'h0, 5'd4);
      @(posedge clk); #1;
      idle_req();
      @(posedge clk); #1;
      drive_req(1'b0, 3'b010, 32'd8, 32'h0, 5'd5);
      bus.flush = 1'b1;
      @(negedge clk);
      check("resp flush resp_valid", 32'(bus.resp_valid), 32'd0);
      check("resp flush req_ready",  32'(bus.req_ready),  32'd1);
      @(posedge clk); #1;
      idle_req();
      bus.flush = 1'b0;
      @(negedge clk);
      check("resp flush dropped busy",      32'(bus.busy),  32'd0);
      check("resp flush dropped mem_rd_en", 32'(mem_rd_en), 32'd0);
      @(negedge clk);
      check("resp flush no late resp", 32'(bus.resp_valid), 32'd0);

      // ---------------- reset asserted mid-ACCESS of SW ----------------
      @(posedge clk); #1;
      w0 = wr_pulses;
      drive_req(1'b1, 3'b010, 32'd16, 32'hCAFEF00D, 5'd6);
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      check("rst pre mem_wr_en", 32'(mem_wr_en), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst mem_wr_en",  32'(mem_wr_en),      32'd0);
      check("rst busy",       32'(bus.busy),       32'd0);
      check("rst req_ready",  32'(bus.req_ready),  32'd1);
      check("rst mem_addr",   mem_addr,            32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst ready after release", 32'(bus.req_ready), 32'd1);
      check("rst memory word 16",
            {mem_model[19], mem_model[18], mem_model[17], mem_model[16]}, 32'h0);
      check("rst write pulses", 32'(wr_pulses - w0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control stage sitting directly upstream of the byte-addressed data memory in the 3-stage pipeline. Accepts one memory request per handshake from the execute/memory stage, validates it, translates RISC-V funct3 into the data memory's mem_type encoding, and drives the memory's rd_en/wr_en/mem_type/addr/wdata for exactly one cycle. For loads it registers the returned data and applies sign/zero extension before handing a response to writeback. It exports busy so the pipeline can stall.

## Interface
- DEPTH_BYTES, 32, number of addressable bytes in the data memory; accesses ending at or beyond this are errors
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  stage can accept; high in IDLE and RESP, low in ACCESS
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- req_rd  input  5  load destination register
- flush  input  1  kill the in-flight request
- mem_rd_en  output  1  to data memory
- mem_wr_en  output  1  to data memory
- mem_type  output  3  000 byte, 001 half, 010 word, 011 byte-unsigned, 100 half-unsigned
- mem_addr  output  32  to data memory
- mem_wdata  output  32  to data memory
- mem_rdata  input  32  asynchronous read data from memory
- resp_valid  output  1  one-cycle response pulse
- resp_wb  output  1  response writes a register (load, no error)
- resp_rd  output  5  destination register
- resp_data  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  illegal funct3 or out-of-range access
- busy  output  1  high while in ACCESS

## Operation
- States: IDLE, ACCESS, RESP. Reset value of every output 0, except req_ready = 1; state = IDLE.
- IDLE/RESP: on req_valid && req_ready, capture we/funct3/addr/wdata/rd, compute err, go to ACCESS; otherwise RESP -> IDLE.
- ACCESS: drive mem_* from captured regs; mem_rd_en = !we && !err; mem_wr_en = we && !err && !flush. Always -> RESP (or IDLE if flush).
- funct3 mapping: load 000->000, 001->001, 010->010, 100->011, 101->100; store 000->000, 001->001, 010->010. Any other funct3 (load 011/110/111, store 011-111) sets err.
- Size = 1/2/4 bytes; err also if addr + size > DEPTH_BYTES (compute in 33 bits, no wrap). Misalignment is legal (byte memory).
- At end of ACCESS for a legal load, register extended data: byte = mem_rdata[7:0] sign- or zero-extended, half = mem_rdata[15:0] likewise, word = full.
- RESP: resp_valid = 1 for one cycle; resp_wb = !we && !err; resp_rd = captured rd; resp_err = err.
- mem_* outputs are 0 outside ACCESS.
- flush in ACCESS: store write suppressed, no response, next state IDLE. flush in RESP: resp_valid suppressed; a request accepted the same cycle is also discarded (ready is still high but capture is ignored). flush in IDLE: no effect.
- Reset asserted mid-operation: immediately IDLE, mem_wr_en drops, no write, no response.

## Timing
- Request accepted at edge N; ACCESS during cycle N..N+1; memory write occurs at edge N+1; resp_valid during cycle N+1..N+2.
- Load latency 2 cycles accept-to-response; peak throughput one request per 2 cycles (back-to-back accept in RESP).
- busy is the registered state, glitch-free; req_ready is combinational from state only (no dependency on req_valid).

## Structure
- Package lsu_pkg: state enum (IDLE, ACCESS, RESP), mem_type constants, funct3 constants for loads/stores, DEPTH_BYTES default.
- One sub-module: lsu_load_ext, combinational extender (mem_type, rdata) -> 32-bit result.

## Test plan
- Reset: rst_n low mid-ACCESS with store -> no mem write, all outputs 0, req_ready 1 after release.
- SW 0xDEADBEEF to addr 4, then LB addr 7 -> resp_data 0xFFFFFFDE, resp_wb 1; LBU addr 7 -> 0x000000DE; LH addr 6 -> 0xFFFFDEAD.
- Back-to-back: load accepted in RESP of previous store -> resp_valid every 2 cycles, mem_wr_en exactly one cycle per store.
- Range: LW addr 29 (DEPTH_BYTES 32) -> resp_err 1, resp_data 0, mem_rd_en never high; LW addr 28 -> legal.
- Illegal funct3: load 011 and store 100 -> resp_err 1, no memory enables.
- Flush: flush during ACCESS of SB -> memory unchanged, no resp_valid, state IDLE next cycle.
